// File: rtl/cbfp_scale_ctrl_pkg.sv
// Shared constants, types and the per-lane scaling function for the CBFP scaling controller.
// Build option: CBFP_SCALE_ROUND_EN selects round-half-up with saturation instead of plain truncation.
package cbfp_pkg;

    localparam int DATA_WIDTH = 23;
    localparam int OUT_WIDTH  = 11;
    localparam int MAG_WIDTH  = 5;
    localparam int BEATS      = 4;
    localparam int LANES      = 16;
    localparam int CNT_W      = $clog2(BEATS);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [OUT_WIDTH-1:0]  osample_t;
    typedef logic        [MAG_WIDTH-1:0]  mag_t;

    typedef sample_t  [LANES-1:0] beat_t;
    typedef osample_t [LANES-1:0] obeat_t;
    typedef mag_t     [LANES-1:0] mag_beat_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    localparam mag_t MAG_MAX = mag_t'(DATA_WIDTH - 1);

`ifdef CBFP_SCALE_ROUND_EN
    localparam osample_t OSAMPLE_MAX = osample_t'((1 << (OUT_WIDTH - 1)) - 1);
    localparam osample_t OSAMPLE_MIN = osample_t'(1 << (OUT_WIDTH - 1));
`endif

    // Normalise one sample by the block exponent and keep the top OUT_WIDTH bits.
    function automatic osample_t scale_sample(input sample_t s, input mag_t sh_amt);
        sample_t shifted;
`ifdef CBFP_SCALE_ROUND_EN
        logic signed [OUT_WIDTH+1:0] ext;
        logic signed [OUT_WIDTH:0]   rnd;
`endif
        shifted = s <<< sh_amt;
`ifdef CBFP_SCALE_ROUND_EN
        // Keep one extra LSB, add it in, then drop it: round-half-up.
        ext = (OUT_WIDTH+2)'(shifted >>> (DATA_WIDTH - OUT_WIDTH - 1));
        ext = ext + (OUT_WIDTH+2)'(1);
        rnd = (OUT_WIDTH+1)'(ext >>> 1);
        if (rnd[OUT_WIDTH] != rnd[OUT_WIDTH-1])
            return rnd[OUT_WIDTH] ? OSAMPLE_MIN : OSAMPLE_MAX;
        return osample_t'(rnd);
`else
        return osample_t'(shifted >>> (DATA_WIDTH - OUT_WIDTH));
`endif
    endfunction

endpackage

// File: rtl/cbfp_scale_ctrl_if.sv
// Streaming bus between the magnitude detector, the CBFP scaling controller and its consumer.
// The slave modport is the controller side; the master modport drives samples and observes results.
interface cbfp_scale_ctrl_if;
    import cbfp_pkg::*;

    logic      valid_in;
    beat_t     din;
    mag_beat_t mag_in;

    logic      valid_out;
    obeat_t    dout;
    mag_t      exp_out;
    logic      blk_first;
    logic      blk_last;

    modport master (
        output valid_in, din, mag_in,
        input  valid_out, dout, exp_out, blk_first, blk_last
    );

    modport slave (
        input  valid_in, din, mag_in,
        output valid_out, dout, exp_out, blk_first, blk_last
    );

endinterface

// File: rtl/cbfp_scale_ctrl_min_tree.sv
// Combinational minimum of the 16 per-lane redundant-sign-bit counts of one beat.
// Balanced four-level compare tree.
module cbfp_min_tree
    import cbfp_pkg::*;
(
    input  mag_beat_t mag_i,
    output mag_t      min_o
);

    mag_t l1 [8];
    mag_t l2 [4];
    mag_t l3 [2];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_l1
            assign l1[gi] = (mag_i[2*gi] < mag_i[2*gi+1]) ? mag_i[2*gi] : mag_i[2*gi+1];
        end
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_l2
            assign l2[gi] = (l1[2*gi] < l1[2*gi+1]) ? l1[2*gi] : l1[2*gi+1];
        end
        for (gi = 0; gi < 2; gi = gi + 1) begin : g_l3
            assign l3[gi] = (l2[2*gi] < l2[2*gi+1]) ? l2[2*gi] : l2[2*gi+1];
        end
    endgenerate

    assign min_o = (l3[0] < l3[1]) ? l3[0] : l3[1];

endmodule

// File: rtl/cbfp_scale_ctrl.sv
// CBFP scaling controller: collects BEATS-beat blocks into a ping-pong store, then replays them
// normalised by the block exponent. Build option CBFP_SCALE_ROUND_EN enables rounding/saturation.
module cbfp_scale_ctrl
    import cbfp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             sync_clr,
    cbfp_scale_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // Writer state
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;
    logic             wbank_q;
    logic             rbank_q;
    mag_t             rmin_q;
    mag_t             rmin_d;
    mag_t             blk_exp_q;
    mag_t             bmin;
    logic             wr_en;
    logic             blk_done;

    // Reader state and registered outputs
    rd_state_e        state_q;
    logic [CNT_W-1:0] rcnt_q;
    logic             valid_q;
    obeat_t           dout_q;
    mag_t             exp_q;
    logic             first_q;
    logic             last_q;

    beat_t            mem_q [2*BEATS];
    beat_t            rd_beat;
    obeat_t           scaled;

    cbfp_min_tree u_min_tree (
        .mag_i (bus.mag_in),
        .min_o (bmin)
    );

    // A clear in the same cycle as a beat discards that beat.
    assign wr_en    = bus.valid_in && !sync_clr;
    assign blk_done = wr_en && (wcnt_q == LAST_CNT);
    assign wcnt_d   = wcnt_q + 1'b1;
    assign rmin_d   = ((wcnt_q == '0) || (bmin < rmin_q)) ? bmin : rmin_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q    <= '0;
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            rmin_q    <= MAG_MAX;
            blk_exp_q <= '0;
        end else if (sync_clr) begin
            wcnt_q <= '0;
            rmin_q <= MAG_MAX;
        end else if (bus.valid_in) begin
            wcnt_q <= wcnt_d;
            rmin_q <= rmin_d;
            if (wcnt_q == LAST_CNT) begin
                blk_exp_q <= rmin_d;
                rbank_q   <= wbank_q;
                wbank_q   <= ~wbank_q;
            end
        end
    end

    // Sample store holds no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[{wbank_q, wcnt_q}] <= bus.din;
    end

    assign rd_beat = mem_q[{rbank_q, rcnt_q}];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi = gi + 1) begin : g_scale
            assign scaled[gi] = scale_sample(rd_beat[gi], blk_exp_q);
        end
    endgenerate

    // blk_exp_q / rbank_q are sampled before a coinciding block-complete update, so the
    // last beat of one block and the first of the next can be back-to-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RD_IDLE;
            rcnt_q  <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            exp_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (blk_done) begin
                        state_q <= RD_READ;
                        rcnt_q  <= '0;
                    end
                end
                RD_READ: begin
                    valid_q <= 1'b1;
                    dout_q  <= scaled;
                    exp_q   <= blk_exp_q;
                    first_q <= (rcnt_q == '0);
                    last_q  <= (rcnt_q == LAST_CNT);
                    rcnt_q  <= rcnt_q + 1'b1;
                    if ((rcnt_q == LAST_CNT) && !blk_done)
                        state_q <= RD_IDLE;
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign bus.valid_out = valid_q;
    assign bus.dout      = dout_q;
    assign bus.exp_out   = exp_q;
    assign bus.blk_first = first_q;
    assign bus.blk_last  = last_q;

endmodule

// File: tb/tb_cbfp_scale_ctrl.sv
// Self-checking bench for cbfp_scale_ctrl: a scoreboard of expected output beats (data, exponent,
// flags, arrival cycle) is filled as blocks are driven and drained by a negedge monitor.
module tb_cbfp_scale_ctrl;
    import cbfp_pkg::*;

    typedef struct {
        obeat_t dout;
        mag_t   e;
        bit     first;
        bit     last;
        int     cyc;
    } exp_beat_t;

    logic clk;
    logic rstn;
    logic sync_clr;

    cbfp_scale_ctrl_if bus();

    cbfp_scale_ctrl dut (
        .clk      (clk),
        .rstn     (rstn),
        .sync_clr (sync_clr),
        .bus      (bus)
    );

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    exp_beat_t sb_q [$];
    beat_t     blk_buf [BEATS];
    int        nb = 0;
    int        last_e_edge = 0;
    int        pos = 0;
    mag_t      seen_exp;
    obeat_t    seen_dout [BEATS];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Redundant sign bits: leading bits below the MSB equal to the sign.
    function automatic int rsb(input sample_t x);
        int n = 0;
        for (int b = DATA_WIDTH - 2; b >= 0; b--) begin
            if (x[b] != x[DATA_WIDTH-1]) break;
            n++;
        end
        return n;
    endfunction

    function automatic osample_t model_lane(input sample_t x, input int e);
        longint p;
        longint q;
        p = longint'(x) * (longint'(1) << e);
`ifdef CBFP_SCALE_ROUND_EN
        q = (p + (longint'(1) << (DATA_WIDTH - OUT_WIDTH - 1))) >>> (DATA_WIDTH - OUT_WIDTH);
        if (q > (1 << (OUT_WIDTH - 1)) - 1) q = (1 << (OUT_WIDTH - 1)) - 1;
`else
        q = p >>> (DATA_WIDTH - OUT_WIDTH);
`endif
        return osample_t'(q);
    endfunction

    function automatic beat_t rand_beat(input int base_sh);
        beat_t   b;
        sample_t r;
        int      sh;
        for (int l = 0; l < LANES; l++) begin
            r  = sample_t'($urandom);
            sh = base_sh + int'($urandom_range(0, 2));
            if (sh > DATA_WIDTH - 1) sh = DATA_WIDTH - 1;
            b[l] = r >>> sh;
        end
        return b;
    endfunction

    task automatic push_block(input int e_edge);
        int        e = DATA_WIDTH - 1;
        exp_beat_t eb;
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < LANES; l++)
                if (rsb(blk_buf[b][l]) < e) e = rsb(blk_buf[b][l]);
        for (int j = 0; j < BEATS; j++) begin
            for (int l = 0; l < LANES; l++) eb.dout[l] = model_lane(blk_buf[j][l], e);
            eb.e     = mag_t'(e);
            eb.first = (j == 0);
            eb.last  = (j == BEATS - 1);
            eb.cyc   = e_edge + 1 + j;
            sb_q.push_back(eb);
        end
        last_e_edge = e_edge;
    endtask

    task automatic drive_beat(input beat_t d, input bit clr);
        @(posedge clk); #1;
        bus.valid_in = 1'b1;
        bus.din      = d;
        sync_clr     = clr;
        for (int l = 0; l < LANES; l++) bus.mag_in[l] = mag_t'(rsb(d[l]));
        if (clr) begin
            nb = 0;
        end else begin
            blk_buf[nb] = d;
            nb++;
            if (nb == BEATS) begin
                push_block(cyc + 1);
                nb = 0;
            end
        end
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.valid_in = 1'b0;
            sync_clr     = 1'b0;
        end
    endtask

    task automatic sb_monitor();
        exp_beat_t eb;
        forever begin
            @(negedge clk);
            if (bus.valid_out) begin
                if (bus.blk_first) pos = 0; else pos++;
                if (pos < BEATS) seen_dout[pos] = bus.dout;
                seen_exp = bus.exp_out;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: valid_out=1 at cycle %0d, required 0", cyc);
                end else begin
                    eb = sb_q.pop_front();
                    if (cyc !== eb.cyc) begin
                        errors++;
                        $display("FAIL beat_cycle: got %0d required %0d", cyc, eb.cyc);
                    end
                    checks++;
                    if (bus.dout !== eb.dout) begin
                        errors++;
                        $display("FAIL dout: cycle %0d got %h required %h", cyc, bus.dout, eb.dout);
                    end
                    checks++;
                    if (bus.exp_out !== eb.e) begin
                        errors++;
                        $display("FAIL exp_out: cycle %0d got %0d required %0d", cyc, bus.exp_out, eb.e);
                    end
                    checks++;
                    if ({bus.blk_first, bus.blk_last} !== {eb.first, eb.last}) begin
                        errors++;
                        $display("FAIL flags: cycle %0d got first/last=%b%b required %b%b",
                                 cyc, bus.blk_first, bus.blk_last, eb.first, eb.last);
                    end
                    $display("beat cycle=%0d exp=%0d first=%b last=%b dout=%h",
                             cyc, bus.exp_out, bus.blk_first, bus.blk_last, bus.dout);
                end
            end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_beat: valid_out=0 at cycle %0d, required 1", cyc);
                void'(sb_q.pop_front());
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
        drive_idle(3);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.valid_out); end
        checks++;
        if (bus.dout !== '0) begin errors++; $display("FAIL rst_dout: got %h required 0", bus.dout); end
        checks++;
        if (bus.exp_out !== '0) begin errors++; $display("FAIL rst_exp: got %0d required 0", bus.exp_out); end
        checks++;
        if (bus.blk_first !== 1'b0) begin errors++; $display("FAIL rst_first: got %b required 0", bus.blk_first); end
        checks++;
        if (bus.blk_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b required 0", bus.blk_last); end
    endtask

    task automatic test_zero_block();
        beat_t b;
        b = '0;
        for (int j = 0; j < BEATS; j++) drive_beat(b, 1'b0);
        drive_idle(1);
        wait_drain("zero");
        checks++;
        if (seen_exp !== mag_t'(22)) begin errors++; $display("FAIL zero_exp: got %0d required 22", seen_exp); end
        checks++;
        if (seen_dout[3] !== '0) begin errors++; $display("FAIL zero_dout: got %h required 0", seen_dout[3]); end
        b = '1;
        for (int j = 0; j < BEATS; j++) drive_beat(b, 1'b0);
        drive_idle(1);
        wait_drain("minus_one");
        checks++;
        if (seen_exp !== mag_t'(22)) begin errors++; $display("FAIL m1_exp: got %0d required 22", seen_exp); end
        checks++;
        if (seen_dout[0][0] !== osample_t'(-1024)) begin
            errors++; $display("FAIL m1_dout: got %0d required -1024", seen_dout[0][0]);
        end
    endtask

    task automatic test_single_lane();
        beat_t z;
        beat_t b;
        z = '0;
        b = '0;
        b[5] = sample_t'(1000);
        drive_beat(z, 1'b0);
        drive_beat(b, 1'b0);
        drive_beat(z, 1'b0);
        drive_beat(z, 1'b0);
        drive_idle(1);
        wait_drain("single");
        checks++;
        if (seen_exp !== mag_t'(12)) begin errors++; $display("FAIL single_exp: got %0d required 12", seen_exp); end
        checks++;
        if (seen_dout[1][5] !== osample_t'(1000)) begin
            errors++; $display("FAIL single_lane: got %0d required 1000", seen_dout[1][5]);
        end
        checks++;
        if (seen_dout[1][4] !== '0) begin errors++; $display("FAIL single_other: got %0d required 0", seen_dout[1][4]); end
    endtask

    task automatic test_full_scale();
        beat_t z;
        beat_t b;
        z = '0;
        b = '0;
        b[0] = sample_t'(23'h3FFFFF);
        drive_beat(b, 1'b0);
        for (int j = 1; j < BEATS; j++) drive_beat(z, 1'b0);
        drive_idle(1);
        wait_drain("full");
        checks++;
        if (seen_exp !== '0) begin errors++; $display("FAIL full_exp: got %0d required 0", seen_exp); end
        checks++;
        if (seen_dout[0][0] !== osample_t'(11'h3FF)) begin
            errors++; $display("FAIL full_dout: got %h required 3ff", seen_dout[0][0]);
        end
        // Top bits are 0x3FF with the next bit set: rounding must saturate rather than wrap.
        b[0] = sample_t'(23'h3FF800);
        drive_beat(b, 1'b0);
        for (int j = 1; j < BEATS; j++) drive_beat(z, 1'b0);
        drive_idle(1);
        wait_drain("sat");
        checks++;
        if (seen_dout[0][0] !== osample_t'(11'h3FF)) begin
            errors++; $display("FAIL sat_dout: got %h required 3ff", seen_dout[0][0]);
        end
    endtask

    task automatic test_back_to_back();
        int shifts [3] = '{3, 9, 15};
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < BEATS; j++) drive_beat(rand_beat(shifts[k]), 1'b0);
        drive_idle(1);
        wait_drain("b2b");
    endtask

    task automatic test_gaps();
        for (int j = 0; j < 2 * BEATS; j++) begin
            drive_beat(rand_beat(int'($urandom_range(0, 18))), 1'b0);
            drive_idle(int'($urandom_range(0, 2)));
        end
        drive_idle(1);
        wait_drain("gaps");
    endtask

    task automatic test_sync_clr();
        for (int j = 0; j < BEATS; j++) drive_beat(rand_beat(4), 1'b0);
        drive_beat(rand_beat(0), 1'b0);
        drive_beat(rand_beat(0), 1'b0);
        drive_beat(rand_beat(0), 1'b1);
        for (int j = 0; j < BEATS; j++) drive_beat(rand_beat(10), 1'b0);
        drive_idle(1);
        wait_drain("clr");
    endtask

    task automatic test_reset_mid();
        int g = 0;
        for (int j = 0; j < BEATS; j++) drive_beat(rand_beat(6), 1'b0);
        drive_idle(1);
        while (cyc < last_e_edge + 2 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        checks++;
        if (g >= 50) begin errors++; $display("FAIL rst_mid_wait: cycle %0d required %0d", cyc, last_e_edge + 2); end
        #1;
        sb_q.delete();
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b required 0", bus.valid_out); end
        checks++;
        if (bus.dout !== '0) begin errors++; $display("FAIL rst_mid_dout: got %h required 0", bus.dout); end
        nb = 0;
        @(negedge clk); #1;
        rstn = 1'b1;
        for (int j = 0; j < BEATS; j++) drive_beat(rand_beat(2), 1'b0);
        drive_idle(1);
        wait_drain("after_rst");
    endtask

    initial begin
        rstn         = 1'b0;
        sync_clr     = 1'b0;
        bus.valid_in = 1'b0;
        bus.din      = '0;
        bus.mag_in   = '0;
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        rstn = 1'b1;
        fork
            sb_monitor();
        join_none
        test_zero_block();
        test_single_lane();
        test_full_scale();
        test_back_to_back();
        test_gaps();
        test_sync_clr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
